debug_loader: RTL

Host-side control unit for the MIPS pipeline. It consumes a byte stream from the UART receiver and drives the pipeline's instruction-memory write port and halt input. It loads programs word by word, starts free-running execution, and single-steps the pipeline. It reports completion back to the host through a byte transmit handshake toward the UART transmitter.

---
 rtl/debug_loader_if.sv | 32 +++
 rtl/debug_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/debug_loader_if.sv
// Host-side bus of the debug loader: UART rx/tx byte handshakes,
// pipeline halt/status, and the instruction-memory write port.
interface debug_loader_if;
    // UART receive side
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    // Pipeline status
    logic        i_program_end;
    // UART transmit side
    logic        i_tx_ready;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    // Pipeline control and instruction-memory write port
    logic        o_halt;
    logic        o_write_instruction_mem;
    logic [31:0] o_instruction_mem_addr;
    logic [31:0] o_instruction_mem_data;

    // Environment side: UART, pipeline and memory around the loader
    modport master (
        output i_rx_valid, i_rx_data, i_program_end, i_tx_ready,
        input  o_tx_valid, o_tx_data, o_halt,
               o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data
    );

    // Loader side
    modport slave (
        input  i_rx_valid, i_rx_data, i_program_end, i_tx_ready,
        output o_tx_valid, o_tx_data, o_halt,
               o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data
    );
endinterface

// File: rtl/debug_loader.sv
// Debug loader: decodes host command bytes to load instruction memory,
// run the pipeline to HALT, or single-step it, then reports to the host.
module debug_loader #(
    parameter int unsigned ADDR_STEP = 4,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  END_BYTE  = 8'h45
) (
    input  logic           i_clk,
    input  logic           i_reset,
    debug_loader_if.slave  bus
);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COUNT,
        LOAD_BYTES,
        WRITE,
        RUN,
        STEP,
        SEND
    } state_t;

    state_t      state;
    logic [7:0]  word_count;
    logic [31:0] addr;
    logic [31:0] asm_data;
    logic [1:0]  byte_idx;

    // Command FSM with all outputs registered; reset wins over every state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                       <= IDLE;
            word_count                  <= 8'd0;
            addr                        <= 32'd0;
            asm_data                    <= 32'd0;
            byte_idx                    <= 2'd0;
            bus.o_halt                  <= 1'b1;
            bus.o_write_instruction_mem <= 1'b0;
            bus.o_instruction_mem_addr  <= 32'd0;
            bus.o_instruction_mem_data  <= 32'd0;
            bus.o_tx_valid              <= 1'b0;
            bus.o_tx_data               <= 8'd0;
        end else begin
            bus.o_write_instruction_mem <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_rx_valid) begin
                        case (bus.i_rx_data)
                            CMD_LOAD: state <= LOAD_COUNT;
                            CMD_RUN: begin
                                state      <= RUN;
                                bus.o_halt <= 1'b0;
                            end
                            CMD_STEP: begin
                                state      <= STEP;
                                bus.o_halt <= 1'b0;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end

                LOAD_COUNT: begin
                    if (bus.i_rx_valid) begin
                        word_count <= bus.i_rx_data;
                        addr       <= 32'd0;
                        byte_idx   <= 2'd0;
                        if (bus.i_rx_data == 8'd0) begin
                            state          <= SEND;
                            bus.o_tx_valid <= 1'b1;
                            bus.o_tx_data  <= ACK_BYTE;
                        end else begin
                            state <= LOAD_BYTES;
                        end
                    end
                end

                // Little-endian assembly; the 4th byte launches the write directly.
                LOAD_BYTES: begin
                    if (bus.i_rx_valid) begin
                        asm_data[{byte_idx, 3'b000} +: 8] <= bus.i_rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state                       <= WRITE;
                            bus.o_write_instruction_mem <= 1'b1;
                            bus.o_instruction_mem_addr  <= addr;
                            bus.o_instruction_mem_data  <= {bus.i_rx_data, asm_data[23:0]};
                        end
                    end
                end

                WRITE: begin
                    addr       <= addr + 32'(ADDR_STEP);
                    word_count <= word_count - 8'd1;
                    if (word_count == 8'd1) begin
                        state          <= SEND;
                        bus.o_tx_valid <= 1'b1;
                        bus.o_tx_data  <= ACK_BYTE;
                    end else begin
                        state <= LOAD_BYTES;
                    end
                end

                RUN: begin
                    if (bus.i_program_end) begin
                        state          <= SEND;
                        bus.o_halt     <= 1'b1;
                        bus.o_tx_valid <= 1'b1;
                        bus.o_tx_data  <= END_BYTE;
                    end
                end

                // One free cycle of pipeline advance, then acknowledge.
                STEP: begin
                    state          <= SEND;
                    bus.o_halt     <= 1'b1;
                    bus.o_tx_valid <= 1'b1;
                    bus.o_tx_data  <= ACK_BYTE;
                end

                SEND: begin
                    if (bus.o_tx_valid && bus.i_tx_ready) begin
                        state          <= IDLE;
                        bus.o_tx_valid <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    bus.o_halt <= 1'b1;
                end
            endcase
        end
    end

endmodule
